// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request channel, datapath
// redirect, and the instruction handshake toward the datapath.
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight,
// buffers returned words in a small prefetch FIFO and hands them to the
// datapath. A redirect flushes the FIFO and drops the stale in-flight fetch.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | requesting fetch_pc whenever the FIFO has room
// DISCARD | waiting out a request issued before a redirect; data dropped
module if_fetch_unit #(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter int                     PC_STEP     = 4,
    parameter int                     FIFO_DEPTH  = 2
) (
    input  logic clk,
    input  logic reset,
    if_fetch_unit_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  stale_addr;
    logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   req;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   push;
    logic                   pop;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // A redirect in the same cycle wins over a datapath pop.
    assign pop = !fifo_empty && bus.instr_ready && !bus.redirect_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, request generation and push decision.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        addr      = fetch_pc;
        push      = 1'b0;
        case (state)
            FETCH: begin
                // Requesting only with room left guarantees an ack never hits a full FIFO.
                req  = !fifo_full;
                addr = fetch_pc;
                push = req && bus.imem_ack && !bus.redirect_valid;
                if (bus.redirect_valid && req && !bus.imem_ack) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                req  = 1'b1;
                addr = stale_addr;
                if (bus.imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Program counter and the address held while a stale fetch drains.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc   <= RESET_PC;
            stale_addr <= RESET_PC;
        end else begin
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
            end
            if (state == FETCH && state_nxt == DISCARD) begin
                stale_addr <= fetch_pc;
            end
        end
    end

    // Prefetch FIFO; storage is cleared on reset so the outputs never carry X.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= bus.imem_rdata;
                fifo_pc[wr_ptr]    <= fetch_pc;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Outputs are forced to their idle values while reset is held low.
    always_comb begin
        bus.imem_req    = reset && req;
        bus.imem_addr   = reset ? addr : RESET_PC;
        bus.instr_valid = reset && !fifo_empty;
        bus.instr       = reset ? fifo_instr[rd_ptr] : '0;
        bus.instr_pc    = reset ? fifo_pc[rd_ptr] : '0;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage directly upstream of CPU_DataPath.
- Holds the program counter and issues single-outstanding requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents {instr, instr_pc} to the datapath over a valid/ready handshake.
- Accepts branch/jump redirects from the datapath; a redirect flushes the FIFO and discards the stale in-flight fetch.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address
- INSTR_WIDTH, 32, instruction word width
- RESET_PC, 0, PC loaded at reset
- PC_STEP, 4, PC increment per fetched word
- FIFO_DEPTH, 2, prefetch entries (power of two, ≥2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- imem_req  output  1  fetch request; held with imem_addr stable until imem_ack
- imem_addr  output  ADDR_WIDTH  fetch address
- imem_ack  input  1  request complete, imem_rdata valid this cycle (may coincide with the first req cycle)
- imem_rdata  input  INSTR_WIDTH  fetched word
- redirect_valid  input  1  one-cycle pulse: PC change from the datapath
- redirect_pc  input  ADDR_WIDTH  new PC target
- instr_valid  output  1  FIFO head valid
- instr  output  INSTR_WIDTH  FIFO head instruction
- instr_pc  output  ADDR_WIDTH  PC of FIFO head
- instr_ready  input  1  datapath consumes head when instr_valid & instr_ready

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc=RESET_PC, FIFO count=0, state=FETCH.
  - Outputs while in reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - Reset overrides everything, including any in-flight ack; nothing is pushed.
- First request: in the first cycle with reset==1, imem_req=1 and imem_addr=RESET_PC.
- States:
  - FETCH: imem_req = (count < FIFO_DEPTH); imem_addr = fetch_pc.
    - On imem_ack with no redirect: push {imem_rdata, fetch_pc}; fetch_pc += PC_STEP (wraps mod 2^ADDR_WIDTH).
  - DISCARD: imem_req=1; imem_addr = the stale address, held.
    - On imem_ack: drop the data; go to FETCH.
    - fetch_pc already holds the redirect target.
- Request and FIFO space:
  - Single outstanding request; addr is never changed while req=1 and ack has not arrived.
  - Request is made only while the FIFO is not full, so an ack can never hit a full FIFO.
  - At full: imem_req=0 (stall). Resumes the cycle after a pop frees a slot.
- Datapath handshake:
  - instr_valid = (count != 0); instr and instr_pc come from the head. All outputs are registered/FIFO-driven, with no combinational path from imem_rdata.
  - Zero-latency pass-through is not required: a word acked in cycle N is visible at the head in cycle N+1 at the earliest.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
- Redirect (redirect_valid=1 at posedge):
  - FIFO flushed (count=0, pointers reset); instr_valid=0 next cycle. A pop that same cycle is ignored.
  - fetch_pc = redirect_pc.
  - If req=1 and no ack this cycle: go to DISCARD.
  - If ack arrives the same cycle: discard that word and stay in FETCH; next cycle req=1 with addr=redirect_pc.
  - If req=0 (FIFO full): go to FETCH; next cycle req=1 with addr=redirect_pc.
  - Redirect while in DISCARD: update fetch_pc only (latest redirect wins); stay in DISCARD until ack.
- Redirect and reset together: reset wins.
- No X propagation: all registers reset, including FIFO storage.

Test Plan:
- Reset then release, memory acks in the same cycle with rdata=addr^32'hA5A5_0000, instr_ready=1 → instr_pc sequence 0,4,8,C…; instr matches; one instruction per cycle after 2-cycle startup.
- instr_ready=0 for 6 cycles → imem_req drops after 2 words buffered; head holds PC 0; ready=1 → resumes at PC 8, no word lost or duplicated.
- Memory ack delayed 3 cycles → imem_req/imem_addr held stable for all 3 wait cycles; single push per ack.
- redirect_valid with redirect_pc=0x100 while request to 0x10 is waiting → instr_valid=0 next cycle; addr 0x10 held until ack, its data dropped; next request addr 0x100; first delivered instr_pc=0x100.
- Redirect coincident with ack, and second redirect to 0x200 during DISCARD → stale words never appear on instr; next fetch is 0x200.
- reset=0 asserted mid-fetch with ack pending → next cycle imem_req=0, instr_valid=0; after release, first addr=RESET_PC.
- RESET_PC=32'hFFFF_FFFC → second fetch address wraps to 0.
